ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device transmitter for the PS/2 keyboard port: the sending direction that complements the existing PS/2 keyboard receiver. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). The transmit sequence is:

- inhibit the clock line;
- issue a request-to-send;
- shift out 8 data bits, odd parity and stop, in step with the keyboard's clock;
- check the device ACK.

The block drives the shared PS2C/PS2D pins through open-drain enables and asks the receiver to ignore the bus while a transfer is in progress.

## Interface

Parameters:
- CLK_HZ, 100_000_000: system clock frequency (informational).
- INHIBIT_CYCLES, 10_000: cycles PS2C is held low before request-to-send (100 µs at 100 MHz).
- SETUP_CYCLES, 100: cycles PS2D is low before PS2C is released.
- TIMEOUT_CYCLES, 2_000_000: maximum cycles from PS2C release to ACK and bus idle (20 ms).
- FILTER_LEN, 8: consecutive identical synced samples needed to accept a new PS2C level.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset. One clock; reset is synchronous and active-low (`rst` low resets).
- tx_data, in, 8: command byte.
- tx_valid, in, 1: transfer request. Accepted only when tx_ready=1.
- tx_ready, out, 1: high in IDLE only.
- tx_done, out, 1: one-cycle pulse when a transfer completes with a valid ACK.
- tx_err, out, 1: one-cycle pulse on missing ACK or timeout.
- rx_inhibit, out, 1: high whenever the block is not in IDLE. The receiver discards frames while it is high.
- ps2c_in, in, 1: raw PS2C pin level.
- ps2d_in, in, 1: raw PS2D pin level.
- ps2c_oe, out, 1: 1 pulls PS2C low; 0 releases it.
- ps2d_oe, out, 1: 1 pulls PS2D low; 0 releases it.

## Operation

Input conditioning:
- ps2c_in and ps2d_in each pass through a 2-flop synchronizer.
- PS2C is then filtered: the filtered level changes only after FILTER_LEN equal samples.
- A falling edge means the filtered level went 1→0.

Transmit setup:
- On acceptance: latch tx_data; parity = ~^tx_data (odd parity); bit counter = 0.

States:
- IDLE: both output enables = 0, tx_ready = 1. If tx_valid is high, go to INHIBIT.
- INHIBIT: ps2c_oe = 1 for INHIBIT_CYCLES, then go to RTS.
- RTS: ps2c_oe = 1 and ps2d_oe = 1 (start bit = 0) for SETUP_CYCLES. Then set ps2c_oe = 0, clear the timeout counter, and go to SHIFT.
- SHIFT: on each PS2C falling edge n (n = 1..10), drive the next value onto PS2D:
  - edges 1–8: data bit n−1, LSB first;
  - edge 9: parity;
  - edge 10: release PS2D (stop bit = 1).
  - Driving a bit means ps2d_oe = ~bit.
  - After edge 10, go to ACK.
- ACK: at the next falling edge (edge 11), sample the synced PS2D.
  - 0 = ACK: go to WAIT_IDLE.
  - 1 = no ACK: pulse tx_err and go to WAIT_IDLE with the error already reported.
- WAIT_IDLE: wait until filtered PS2C = 1 and synced PS2D = 1. Then go to IDLE, pulsing tx_done only if ACK was good.

Timeout:
- The timeout counter runs in SHIFT, ACK and WAIT_IDLE.
- When it reaches TIMEOUT_CYCLES: release both lines, pulse tx_err, go to IDLE.
- At most one of tx_done/tx_err pulses per transfer.

Other rules:
- tx_valid outside IDLE is ignored; it is not queued.
- Reset (rst = 0, sampled at a clock edge) from any state:
  - state = IDLE;
  - ps2c_oe = 0, ps2d_oe = 0;
  - tx_ready = 1, tx_done = 0, tx_err = 0, rx_inhibit = 0;
  - synchronizers and filter preset to 1;
  - counters = 0.
- A reset mid-transfer therefore releases the bus on the next clock.

## Timing

- All outputs are registered and are at their reset values after reset.
- tx_ready falls, and ps2c_oe/rx_inhibit rise, one cycle after the cycle in which tx_valid and tx_ready are both high.
- ps2d_oe rises exactly INHIBIT_CYCLES cycles after ps2c_oe rises.
- ps2c_oe falls exactly SETUP_CYCLES cycles after that.
- PS2C-to-output latency: 2 sync + FILTER_LEN filter + 1 register ≈ 11 cycles from a pin falling edge to the ps2d_oe update. This is far below the ≥5 µs low phase of the keyboard clock.
- tx_done/tx_err are high for exactly one cycle. tx_ready and rx_inhibit return to their IDLE values in the same cycle as the pulse.
- A new transfer is accepted no earlier than the cycle after tx_done/tx_err.

## Test plan

- **Nominal 0xED.** Device model clocks at 12.5 kHz and ACKs. PS2D sampled on rising edges must read 0 (start), then 1,0,1,1,0,1,1,1, parity 1, stop 1. Expect one tx_done pulse, no tx_err, rx_inhibit high throughout.
- **Parity.** Send 0x07, expect parity bit 0; send 0x00, expect parity 1. Check INHIBIT/RTS durations are exactly 10_000 and 100 cycles.
- **No ACK.** Device leaves PS2D high at edge 11 with 0xFF. Expect one tx_err pulse, no tx_done, both enables 0, tx_ready = 1 once the bus is idle.
- **Device silent.** No clocks after the release. Expect tx_err exactly TIMEOUT_CYCLES cycles after ps2c_oe falls, and both lines released.
- **Reset mid-SHIFT.** Drop rst after edge 4. Next cycle: both enables 0, tx_ready = 1, no done/err pulse. A following 0xF4 transfer completes normally.
- **Robustness.** tx_valid held high during a transfer with a different byte: it is ignored and only the original byte is sent. 3-cycle glitches on PS2C produce no extra bit shifts.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: holds the clock low, issues request-to-send,
// shifts one command byte out on the keyboard's clock and checks the device ACK.
module ps2_host_tx #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int SETUP_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
                         ? ((TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES)
                         : ((INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int FW    = $clog2(FILTER_LEN + 1);

  // The filter delay must stay well inside the keyboard's 5 us clock low phase.
  if (FILTER_LEN + 3 > CLK_HZ / 200_000) begin : g_filter_too_long
    $error("ps2_host_tx: FILTER_LEN too long for CLK_HZ");
  end

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t           state, state_next;
  logic [1:0]       c_sync, d_sync;
  logic             c_filt;
  logic [FW-1:0]    filt_cnt;
  logic             filt_flip, c_fall;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bit_cnt;
  logic             ack_ok;
  logic             timed_out, bus_idle;
  logic             done_next, err_next, c_oe_next, d_oe_next;

  assign filt_flip = (c_sync[1] != c_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign c_fall    = filt_flip && c_filt;
  assign bus_idle  = c_filt && d_sync[1];
  assign timed_out = (state inside {SHIFT, ACK, WAIT_IDLE}) &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Pin synchronizers and PS2C glitch filter; idle bus level is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c_sync   <= 2'b11;
      d_sync   <= 2'b11;
      c_filt   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      c_sync <= {c_sync[0], ps2c_in};
      d_sync <= {d_sync[0], ps2d_in};
      if (c_sync[1] == c_filt) begin
        filt_cnt <= '0;
      end else if (filt_flip) begin
        c_filt   <= c_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bit_cnt    <= '0;
      ack_ok     <= 1'b0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      rx_inhibit <= 1'b0;
      ps2c_oe    <= 1'b0;
      ps2d_oe    <= 1'b0;
    end else begin
      state      <= state_next;
      tx_ready   <= (state_next == IDLE);
      rx_inhibit <= (state_next != IDLE);
      tx_done    <= done_next;
      tx_err     <= err_next;
      ps2c_oe    <= c_oe_next;
      ps2d_oe    <= d_oe_next;
      // The timeout count spans SHIFT, ACK and WAIT_IDLE, so only phase starts clear it.
      if (state == IDLE || (state_next != state && state_next inside {INHIBIT, RTS, SHIFT})) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == IDLE && tx_valid) begin
        data_q   <= tx_data;
        parity_q <= ~^tx_data;
        bit_cnt  <= '0;
      end
      if (state == SHIFT && c_fall) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == ACK && c_fall) begin
        ack_ok <= ~d_sync[1];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (tx_valid) state_next = INHIBIT;
      INHIBIT:   if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) state_next = RTS;
      RTS:       if (cnt == CNT_W'(SETUP_CYCLES - 1)) state_next = SHIFT;
      SHIFT:     if (timed_out) state_next = IDLE;
                 else if (c_fall && bit_cnt == 4'd9) state_next = ACK;
      ACK:       if (timed_out) state_next = IDLE;
                 else if (c_fall) state_next = WAIT_IDLE;
      WAIT_IDLE: if (bus_idle || timed_out) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    done_next = (state == WAIT_IDLE) && bus_idle && ack_ok;
    // A missing ACK is reported once; a later timeout in WAIT_IDLE stays silent.
    err_next  = (state == ACK && c_fall && d_sync[1] && !timed_out) ||
                (timed_out && !(state == WAIT_IDLE && (bus_idle || !ack_ok)));
    c_oe_next = state_next inside {INHIBIT, RTS};
    d_oe_next = 1'b0;
    case (state)
      INHIBIT: d_oe_next = (state_next == RTS);
      RTS:     d_oe_next = 1'b1;
      SHIFT: begin
        d_oe_next = ps2d_oe;
        if (c_fall) begin
          if (bit_cnt < 4'd8)       d_oe_next = ~data_q[bit_cnt[2:0]];
          else if (bit_cnt == 4'd8) d_oe_next = ~parity_q;
          else                      d_oe_next = 1'b0;
        end
      end
      default: d_oe_next = 1'b0;
    endcase
    if (state_next == IDLE) d_oe_next = 1'b0;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural keyboard clocks each frame out,
// table vectors cover nominal/parity/no-ACK/robustness, plus timeout and reset cases.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int SET  = 20;
  localparam int TMO  = 3000;
  localparam int FLEN = 8;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, rx_inhibit, ps2c_oe, ps2d_oe;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = dev_c & ~ps2c_oe;
  assign ps2d_line = dev_d & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES(SET),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLEN)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .rx_inhibit(rx_inhibit),
    .ps2c_in(ps2c_line), .ps2d_in(ps2d_line), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int t_c_rise = 0, t_d_rise = 0, t_c_fall = 0;
  logic c_oe_prev = 1'b0, d_oe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge timestamps and pulse counts, taken away from the active edge.
  always @(negedge clk) begin
    c_oe_prev <= ps2c_oe;
    d_oe_prev <= ps2d_oe;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_err === 1'b1) err_cnt <= err_cnt + 1;
    if (ps2c_oe === 1'b1 && c_oe_prev == 1'b0) t_c_rise <= cyc;
    if (ps2c_oe === 1'b0 && c_oe_prev == 1'b1) t_c_fall <= cyc;
    if (ps2c_oe === 1'b1 && ps2d_oe === 1'b1 && d_oe_prev == 1'b0) t_d_rise <= cyc;
  end

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    bit          glitch;
    bit          hold;
    logic [10:0] frame;
    int          n_done;
    int          n_err;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit hold);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    checkOutput("accept_tx_ready", tx_ready, 0);
    checkOutput("accept_ps2c_oe", ps2c_oe, 1);
    checkOutput("accept_rx_inhibit", rx_inhibit, 1);
    if (hold) tx_data = 8'hAA;
    else tx_valid = 1'b0;
  endtask

  task automatic waitHostRelease(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INH + SET + 50 && !ok; i++) begin
      @(negedge clk);
      if (ps2c_oe === 1'b0 && ps2d_oe === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) ok = 1'b1;
    end
  endtask

  // Keyboard model: reads the start bit, then samples PS2D on each rising clock.
  task automatic runDevice(input bit ack, input bit glitch, input bit hold,
                           output logic [10:0] frame, output bit inh_ok);
    frame  = '0;
    inh_ok = 1'b1;
    repeat (HALF) @(negedge clk);
    frame[0] = ps2d_line;
    for (int n = 1; n <= 10; n++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      frame[n] = ps2d_line;
      inh_ok &= (rx_inhibit === 1'b1);
      dev_c = 1'b1;
      if (glitch) begin
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        repeat (3) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (hold) tx_valid = 1'b0;
    if (ack) dev_d = 1'b0;
    repeat (5) @(negedge clk);
    dev_c = 1'b0;
    repeat (HALF) @(negedge clk);
    inh_ok &= (rx_inhibit === 1'b1);
    dev_c = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_d = 1'b1;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int d0, e0;
    logic [10:0] frame;
    bit ok, inh_ok;
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(v.data, v.hold);
    waitHostRelease(ok);
    checkOutput($sformatf("v%0d_release", idx), ok, 1);
    runDevice(v.ack, v.glitch, v.hold, frame, inh_ok);
    waitReady(ok);
    checkOutput($sformatf("v%0d_back_idle", idx), ok, 1);
    @(negedge clk);
    checkOutput($sformatf("v%0d_frame", idx), frame, v.frame);
    checkOutput($sformatf("v%0d_inhibit_held", idx), inh_ok, 1);
    checkOutput($sformatf("v%0d_done_pulses", idx), done_cnt - d0, v.n_done);
    checkOutput($sformatf("v%0d_err_pulses", idx), err_cnt - e0, v.n_err);
    checkOutput($sformatf("v%0d_ps2c_oe", idx), ps2c_oe, 0);
    checkOutput($sformatf("v%0d_ps2d_oe", idx), ps2d_oe, 0);
    checkOutput($sformatf("v%0d_inhibit_len", idx), t_d_rise - t_c_rise, INH);
    checkOutput($sformatf("v%0d_setup_len", idx), t_c_fall - t_d_rise, SET);
  endtask

  initial begin
    int d0, e0;
    bit ok;

    // Frame layout: {stop, parity, data[7:0], start}, parity worked out by hand.
    vecs[0] = '{data: 8'hED, ack: 1, glitch: 0, hold: 0, frame: 11'b1_1_11101101_0, n_done: 1, n_err: 0};
    vecs[1] = '{data: 8'h07, ack: 1, glitch: 0, hold: 1, frame: 11'b1_0_00000111_0, n_done: 1, n_err: 0};
    vecs[2] = '{data: 8'h00, ack: 1, glitch: 0, hold: 0, frame: 11'b1_1_00000000_0, n_done: 1, n_err: 0};
    vecs[3] = '{data: 8'hFF, ack: 0, glitch: 0, hold: 0, frame: 11'b1_1_11111111_0, n_done: 0, n_err: 1};
    vecs[4] = '{data: 8'hF4, ack: 1, glitch: 1, hold: 0, frame: 11'b1_0_11110100_0, n_done: 1, n_err: 0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_tx_done", tx_done, 0);
    checkOutput("rst_tx_err", tx_err, 0);
    checkOutput("rst_rx_inhibit", rx_inhibit, 0);
    checkOutput("rst_ps2c_oe", ps2c_oe, 0);
    checkOutput("rst_ps2d_oe", ps2d_oe, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_tx_ready", tx_ready, 1);
    checkOutput("idle_ps2c_oe", ps2c_oe, 0);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d: byte %02h", i, vecs[i].data);
      runVector(vecs[i], i);
      repeat (5) @(negedge clk);
    end

    $display("[TB] silent device timeout");
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'h55, 0);
    waitHostRelease(ok);
    checkOutput("tmo_release", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < TMO + 100 && !ok; i++) begin
      @(negedge clk);
      if (tx_err === 1'b1) ok = 1'b1;
    end
    checkOutput("tmo_err_seen", ok, 1);
    checkOutput("tmo_latency", cyc - t_c_fall, TMO);
    checkOutput("tmo_ps2c_oe", ps2c_oe, 0);
    checkOutput("tmo_ps2d_oe", ps2d_oe, 0);
    checkOutput("tmo_tx_ready", tx_ready, 1);
    @(negedge clk);
    checkOutput("tmo_err_pulses", err_cnt - e0, 1);
    checkOutput("tmo_done_pulses", done_cnt - d0, 0);

    $display("[TB] reset during SHIFT");
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'h00, 0);
    waitHostRelease(ok);
    checkOutput("rmid_release", ok, 1);
    repeat (HALF) @(negedge clk);
    for (int n = 1; n <= 4; n++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      if (n < 4) begin
        dev_c = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
    checkOutput("rmid_pre_ps2d_oe", ps2d_oe, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rmid_ps2c_oe", ps2c_oe, 0);
    checkOutput("rmid_ps2d_oe", ps2d_oe, 0);
    checkOutput("rmid_tx_ready", tx_ready, 1);
    checkOutput("rmid_rx_inhibit", rx_inhibit, 0);
    rst = 1'b1;
    dev_c = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("rmid_done_pulses", done_cnt - d0, 0);
    checkOutput("rmid_err_pulses", err_cnt - e0, 0);
    runVector(vecs[4], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
